layer_compositor: RTL
=====================

Name: layer_compositor

Overview:
- Parametrised, pipelined VGA pixel compositor. Successor to the fixed-priority combinational colour mux.
- Takes NUM_LAYERS per-pixel hit signals, selects the highest-priority hit, and looks its colour up in a run-time programmable palette. Emits registered RGB with a fixed 2-tick latency.
- Palette writes are double-buffered and committed only at frame start, so a frame never tears.
- Adds a frame-counted background flash effect, used for player-hit feedback.
- Sits between the per-object render generators and the VGA output pins.

Parameters:
- NUM_LAYERS, 8, number of layer hit inputs; layer 0 has the highest priority.
- COLOR_W, 4, bits per colour channel.
- FLASH_FRAMES, 8, number of frames the flash effect lasts after a request; range 1..255.
- FLASH_COLOR, 12'h444, background colour shown on flash-on frames ({R,G,B}, 3*COLOR_W bits).
- BG_RESET, 12'h111, background palette entry value after reset.
- ADDR_W, $clog2(NUM_LAYERS+1), config address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-low.
- pix_en  in  1  pixel-rate enable (1 cycle in 4 at 100 MHz); the pipeline advances only when high.
- frame_start  in  1  one-cycle pulse at the first line of vblank.
- blank  in  1  VGA blanking for the current pixel.
- layer_hit  in  NUM_LAYERS  per-layer coverage of the current pixel.
- cfg_we  in  1  palette write request.
- cfg_addr  in  ADDR_W  palette index; 0..NUM_LAYERS-1 select layers, NUM_LAYERS selects background.
- cfg_data  in  3*COLOR_W  colour {R,G,B}.
- cfg_ready  out  1  write accepted when cfg_we && cfg_ready.
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_addr > NUM_LAYERS.
- flash_req  in  1  one-cycle pulse that starts or restarts the flash.
- flash_active  out  1  flash counter is nonzero.
- red, green, blue  out  COLOR_W each  registered pixel colour.

Behaviour:
- Reset (reset==0 at a clk edge):
  - all pipeline regs 0; red/green/blue = 0.
  - shadow and active palettes: layers = 0, background = BG_RESET.
  - flash_cnt = 0; cfg_ready = 0; cfg_err = 0.
  - cfg_ready rises 1 cycle after reset is released.
  - A write in progress during reset is dropped.
- Stage 1, on pix_en:
  - idx_q <= index of the lowest set bit of layer_hit (layer 0 wins); if no bit is set, idx_q <= NUM_LAYERS (background).
  - blank_q <= blank.
- Stage 2, on pix_en:
  - if blank_q, RGB <= 0.
  - else if idx_q==NUM_LAYERS && flash_on, RGB <= FLASH_COLOR.
  - else RGB <= active[idx_q].
- Latency and hold: exactly 2 pix_en ticks from inputs to RGB. With pix_en low, all pipeline regs hold.
- Config handshake:
  - An accepted write updates shadow[cfg_addr] the next cycle. Out-of-range addresses leave the shadow unchanged and pulse cfg_err.
  - cfg_ready = 0 in the frame_start cycle; a write presented then stalls (the master holds it) and is accepted the following cycle.
  - On frame_start, active <= shadow, all entries in one cycle.
- Flash counter (8 bits):
  - flash_req: flash_cnt <= FLASH_FRAMES (reload, also when already active).
  - else frame_start && flash_cnt!=0: flash_cnt <= flash_cnt-1.
  - flash_req and frame_start in the same cycle: reload wins, no decrement.
  - flash_on = (flash_cnt!=0) && flash_cnt[0]. Because the counter only changes at frame_start, flash_on toggles once per frame.
  - flash_active = (flash_cnt!=0).
- Palette reads combine with stage 2 only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: LAYER_COMPOSITOR_CLIP_EN.
- Defined:
  - Adds ports clip_region (in, 1; pixel lies outside the game display) and clip_mask (in, NUM_LAYERS; layers to suppress outside it).
  - Stage 1 uses layer_hit & ~(clip_mask & {NUM_LAYERS{clip_region}}).
  - Clip inputs are sampled on pix_en like layer_hit.
- Undefined: the ports are absent and layer_hit is used unmasked.

Decomposition:
- Shared package lc_pkg holds:
  - RGB field widths and slice localparams (R/G/B offsets).
  - The background-index convention (NUM_LAYERS).
  - Default colour constants: BG_RESET, FLASH_COLOR, plus named colours for the game (cyan collider 12'h0EE, red trigger 12'hF33, player 12'h26F).
- One natural sub-module: lc_priority_enc (NUM_LAYERS-bit lowest-set-bit encoder with a no-hit output), instantiated in stage 1.

Test Plan:
- Reset then layer_hit=8'b0000_0000, blank=0 → after 2 pix_en ticks RGB=1,1,1. During reset RGB=0 and cfg_ready=0.
- Write layer 2 = 12'hF33, layer 5 = 12'h0EE, then frame_start; drive layer_hit=8'b0010_0100 → RGB=F,3,3 after 2 ticks. With layer_hit=8'b0010_0000 → 0,E,E.
- Write layer 2 = 12'hABC mid-frame → output stays F,3,3 until the next frame_start, then A,B,C. A write asserted in the frame_start cycle sees cfg_ready=0 and lands one cycle later.
- cfg_addr=NUM_LAYERS+1 write → cfg_err one-cycle pulse, palette unchanged.
- flash_req, then 8 frame_starts with background pixels:
  - flash_cnt runs 8,7,…,0.
  - Background is 4,4,4 while the count is 7,5,3,1 and 1,1,1 otherwise.
  - flash_active falls after the 8th frame_start.
  - flash_req coincident with frame_start at count 3 → count 8.
- blank=1 with layer_hit=8'hFF → RGB=0. pix_en held low for 10 cycles → RGB frozen.

Source files
------------

// File: rtl/lc_pkg.sv
// Shared constants for the layer compositor: colour layout, the background
// index convention and the default palette colours used by the game.
package lc_pkg;

  localparam int unsigned LC_COLOR_W = 4;
  localparam int unsigned LC_RGB_W   = 3 * LC_COLOR_W;

  // Channel offsets inside a packed {R,G,B} word
  localparam int unsigned LC_R_OFF = 2 * LC_COLOR_W;
  localparam int unsigned LC_G_OFF = LC_COLOR_W;
  localparam int unsigned LC_B_OFF = 0;

  localparam logic [LC_RGB_W-1:0] LC_BG_RESET      = 12'h111;
  localparam logic [LC_RGB_W-1:0] LC_FLASH_COLOR   = 12'h444;
  localparam logic [LC_RGB_W-1:0] LC_CYAN_COLLIDER = 12'h0EE;
  localparam logic [LC_RGB_W-1:0] LC_RED_TRIGGER   = 12'hF33;
  localparam logic [LC_RGB_W-1:0] LC_PLAYER        = 12'h26F;

  // The background palette entry sits just past the last layer
  function automatic int unsigned lc_bg_index(input int unsigned num_layers);
    return num_layers;
  endfunction

endpackage

// File: rtl/lc_priority_enc.sv
// Lowest-set-bit encoder: layer 0 has the highest priority.
module lc_priority_enc
  import lc_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 8,
  parameter int unsigned ADDR_W     = $clog2(NUM_LAYERS + 1)
) (
  input  logic [NUM_LAYERS-1:0] i_hit,
  output logic [ADDR_W-1:0]     o_idx,
  output logic                  o_no_hit
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    o_idx = '0;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (i_hit[i]) o_idx = ADDR_W'(i);
    end
  end

  assign o_no_hit = ~|i_hit;

endmodule

// File: rtl/layer_compositor.sv
// Pipelined VGA layer compositor: priority select of layer hits, double-
// buffered palette lookup committed at frame start, frame-counted background
// flash. Fixed 2 pix_en tick latency from inputs to RGB.
// Optional build macro LAYER_COMPOSITOR_CLIP_EN adds clip_region/clip_mask
// to suppress selected layers outside the game display.
module layer_compositor
  import lc_pkg::*;
#(
  parameter int unsigned          NUM_LAYERS   = 8,
  parameter int unsigned          COLOR_W      = LC_COLOR_W,
  parameter int unsigned          FLASH_FRAMES = 8,
  parameter logic [3*COLOR_W-1:0] FLASH_COLOR  = LC_FLASH_COLOR,
  parameter logic [3*COLOR_W-1:0] BG_RESET     = LC_BG_RESET,
  parameter int unsigned          ADDR_W       = $clog2(NUM_LAYERS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_en,
  input  logic                   frame_start,
  input  logic                   blank,
  input  logic [NUM_LAYERS-1:0]  layer_hit,
`ifdef LAYER_COMPOSITOR_CLIP_EN
  input  logic                   clip_region,
  input  logic [NUM_LAYERS-1:0]  clip_mask,
`endif
  input  logic                   cfg_we,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [3*COLOR_W-1:0]   cfg_data,
  output logic                   cfg_ready,
  output logic                   cfg_err,
  input  logic                   flash_req,
  output logic                   flash_active,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue
);

  localparam int unsigned RGB_W   = 3 * COLOR_W;
  localparam int unsigned BG_IDX  = lc_bg_index(NUM_LAYERS);
  localparam int unsigned NUM_ENT = NUM_LAYERS + 1;
  localparam logic [ADDR_W-1:0] BG_ADDR = ADDR_W'(BG_IDX);

  logic [NUM_LAYERS-1:0] w_hit;
  logic [ADDR_W-1:0]     w_enc_idx;
  logic                  w_no_hit;
  logic                  w_cfg_acc;
  logic                  w_addr_ok;
  logic                  w_flash_on;

  logic [ADDR_W-1:0]     r_idx_q;
  logic                  r_blank_q;
  logic [RGB_W-1:0]      r_rgb;
  logic [RGB_W-1:0]      r_shadow [NUM_ENT];
  logic [RGB_W-1:0]      r_active [NUM_ENT];
  logic [7:0]            r_flash_cnt;
  logic                  r_cfg_rdy;
  logic                  r_cfg_err;

`ifdef LAYER_COMPOSITOR_CLIP_EN
  assign w_hit = layer_hit & ~(clip_mask & {NUM_LAYERS{clip_region}});
`else
  assign w_hit = layer_hit;
`endif

  lc_priority_enc #(
    .NUM_LAYERS (NUM_LAYERS),
    .ADDR_W     (ADDR_W)
  ) u_enc (
    .i_hit    (w_hit),
    .o_idx    (w_enc_idx),
    .o_no_hit (w_no_hit)
  );

  // Writes stall during the commit cycle so shadow and active never race
  assign cfg_ready  = r_cfg_rdy & ~frame_start;
  assign w_cfg_acc  = cfg_we & cfg_ready;
  assign w_addr_ok  = (cfg_addr <= BG_ADDR);
  assign w_flash_on = (r_flash_cnt != 8'd0) && r_flash_cnt[0];

  // Stage 1: resolve the winning layer index and delay blank
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx_q   <= '0;
      r_blank_q <= 1'b0;
    end else if (pix_en) begin
      r_idx_q   <= w_no_hit ? BG_ADDR : w_enc_idx;
      r_blank_q <= blank;
    end
  end

  // Stage 2: palette lookup, flash override on background, blanking
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rgb <= '0;
    end else if (pix_en) begin
      if (r_blank_q)                            r_rgb <= '0;
      else if (r_idx_q == BG_ADDR && w_flash_on) r_rgb <= FLASH_COLOR;
      else                                      r_rgb <= r_active[r_idx_q];
    end
  end

  // Config handshake: ready comes up one cycle after reset, error pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cfg_rdy <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_rdy <= 1'b1;
      r_cfg_err <= w_cfg_acc & ~w_addr_ok;
    end
  end

  // Palette: writes land in the shadow, whole shadow copied at frame start
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_ENT; i++) begin
        r_shadow[i] <= (i == BG_IDX) ? BG_RESET : '0;
        r_active[i] <= (i == BG_IDX) ? BG_RESET : '0;
      end
    end else begin
      if (w_cfg_acc && w_addr_ok) r_shadow[cfg_addr] <= cfg_data;
      if (frame_start) begin
        for (int unsigned i = 0; i < NUM_ENT; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  // Flash counter: reload on request, otherwise count frames down to zero
  always_ff @(posedge clk) begin
    if (!reset)                                  r_flash_cnt <= 8'd0;
    else if (flash_req)                          r_flash_cnt <= 8'(FLASH_FRAMES);
    else if (frame_start && r_flash_cnt != 8'd0) r_flash_cnt <= r_flash_cnt - 8'd1;
  end

  assign flash_active = (r_flash_cnt != 8'd0);
  assign cfg_err      = r_cfg_err;
  assign red          = r_rgb[2*COLOR_W +: COLOR_W];
  assign green        = r_rgb[COLOR_W +: COLOR_W];
  assign blue         = r_rgb[0 +: COLOR_W];

endmodule
